// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pulls bytes from the TX FIFO and serialises them as
// start / data (LSB first) / optional parity / stop, with per-frame baud and parity.
module uart_tx_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [7:0]        i_baud,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_pop,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [7:0]        r_timer;
  logic [7:0]        w_next_timer;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [IDX_W-1:0]  w_next_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_next_shift;

  // Frame configuration, captured once per frame so register writes cannot tear a frame
  logic [7:0]        r_baud;
  logic              r_par_en;
  logic              r_par_bit;

  logic              r_tx;
  logic              r_busy;
  logic              r_done;

  logic              w_bit_end;
  logic              w_start_frame;
  logic              w_next_tx;

  assign w_bit_end = (r_timer == 8'd0);

  // A new frame may begin from IDLE or on the final STOP cycle (back-to-back)
  always_comb begin
    w_start_frame = 1'b0;
    case (r_state)
      S_IDLE:  w_start_frame = i_enable && !i_fifo_empty;
      S_STOP:  w_start_frame = w_bit_end && i_enable && !i_fifo_empty;
      default: w_start_frame = 1'b0;
    endcase
  end

  assign o_fifo_pop = w_start_frame && !i_rst;

  always_comb begin
    w_next_state   = r_state;
    w_next_timer   = w_bit_end ? r_baud : (r_timer - 8'd1);
    w_next_bit_idx = r_bit_idx;
    w_next_shift   = r_shift;

    case (r_state)
      S_IDLE: begin
        w_next_timer = 8'd0;
      end
      S_START: begin
        if (w_bit_end) begin
          w_next_state   = S_DATA;
          w_next_bit_idx = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_next_shift = r_shift >> 1;
          if (r_bit_idx == IDX_W'(DATA_W - 1)) begin
            w_next_state = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_next_bit_idx = r_bit_idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_next_state = S_IDLE;
          w_next_timer = 8'd0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_timer = 8'd0;
      end
    endcase

    if (w_start_frame) begin
      w_next_state   = S_START;
      w_next_timer   = i_baud;
      w_next_bit_idx = '0;
      w_next_shift   = i_fifo_data;
    end
  end

  // TX is decoded from the next state so the line itself comes straight off a flop
  always_comb begin
    w_next_tx = 1'b1;
    case (w_next_state)
      S_IDLE:   w_next_tx = 1'b1;
      S_START:  w_next_tx = 1'b0;
      S_DATA:   w_next_tx = w_next_shift[0];
      S_PARITY: w_next_tx = r_par_bit;
      S_STOP:   w_next_tx = 1'b1;
      default:  w_next_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_baud    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_timer   <= w_next_timer;
      r_bit_idx <= w_next_bit_idx;
      r_shift   <= w_next_shift;
      r_tx      <= w_next_tx;
      r_busy    <= (w_next_state != S_IDLE);
      r_done    <= (r_state == S_STOP) && w_bit_end;
      if (w_start_frame) begin
        r_baud    <= i_baud;
        r_par_en  <= i_parity_en;
        r_par_bit <= (^i_fifo_data) ^ i_parity_odd;
      end
    end
  end

  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a frame-level model turns each popped byte into
// its expected per-cycle TX waveform and is compared against the DUT every cycle.
module tb_uart_tx_sequencer;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] baud = 8'd3;
  logic       parityEn = 1'b0;
  logic       parityOdd = 1'b0;
  logic       fifoEmpty = 1'b1;
  logic [7:0] fifoData = 8'h00;
  logic       fifoPop;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] fifoQ[$];
  bitq_t      txq;
  bit         doneFlag = 1'b0;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int popCount = 0;
  int doneCount = 0;
  int busyCount = 0;
  int lastPopCycle = 0;
  int lastDoneCycle = 0;
  int popCycles[$];

  bit expTx, expBusy, expDone, expPop;
  logic [7:0] popped;

  uart_tx_sequencer #(.DATA_W(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_enable    (enable),
    .i_baud      (baud),
    .i_parity_en (parityEn),
    .i_parity_odd(parityOdd),
    .i_fifo_empty(fifoEmpty),
    .i_fifo_data (fifoData),
    .o_fifo_pop  (fifoPop),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
    end
  endtask

  // A frame as a list of line levels, one entry per clock cycle
  function automatic bitq_t buildFrame(input logic [7:0] d, input int b, input bit pen, input bit podd);
    bitq_t f;
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((($countones(d) % 2) == 1) ^ podd);
    bits.push_back(1'b1);
    foreach (bits[k]) for (int c = 0; c <= b; c++) f.push_back(bits[k]);
    return f;
  endfunction

  always @(posedge clk) begin
    #2;
    fifoEmpty = (fifoQ.size() == 0);
    fifoData  = fifoEmpty ? 8'h00 : fifoQ[0];
  end

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      txq.delete();
      doneFlag = 1'b0;
      checkOutput("rstTx", tx, 1);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstPop", fifoPop, 0);
    end else begin
      expBusy = (txq.size() > 0);
      expTx   = expBusy ? txq[0] : 1'b1;
      expDone = doneFlag;
      expPop  = enable && (fifoQ.size() > 0) && (txq.size() <= 1);
      checkOutput("tx", tx, expTx);
      checkOutput("busy", busy, expBusy);
      checkOutput("done", done, expDone);
      checkOutput("pop", fifoPop, expPop);
      doneFlag = (txq.size() == 1);
      if (txq.size() > 0) void'(txq.pop_front());
      if (expPop) begin
        popped = fifoQ.pop_front();
        txq = buildFrame(popped, int'(baud), parityEn, parityOdd);
      end
    end
    if (fifoPop) begin
      popCount++;
      lastPopCycle = cycle;
      popCycles.push_back(cycle);
    end
    if (done) begin
      doneCount++;
      lastDoneCycle = cycle;
    end
    if (busy) busyCount++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int target, input int limit, input string name);
    int k;
    k = 0;
    while (doneCount < target && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (doneCount < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: dones %0d, expected %0d", name, doneCount, target);
    end
  endtask

  task automatic applyStimulus(input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      tick(1);
      if (rst) rst = 1'b0;
      else if ($urandom_range(399) == 0) rst = 1'b1;
      if ($urandom_range(7) == 0 && fifoQ.size() < 4) fifoQ.push_back(8'($urandom_range(255)));
      if ($urandom_range(49) == 0) enable = ~enable;
      if ($urandom_range(19) == 0) baud = 8'($urandom_range(3));
      if ($urandom_range(19) == 0) parityEn = 1'($urandom_range(1));
      if ($urandom_range(19) == 0) parityOdd = 1'($urandom_range(1));
    end
  endtask

  initial begin
    bitq_t f;
    logic [9:0] seq;
    int d0, p0, k;

    f = buildFrame(8'hA5, 3, 1'b0, 1'b0);
    checkOutput("modelLenA5", f.size(), 40);
    for (int i = 0; i < 10; i++) seq[i] = f[4 * i];
    checkOutput("modelBitsA5", seq, 10'b1101001010);
    f = buildFrame(8'h07, 0, 1'b1, 1'b0);
    checkOutput("modelLenPar", f.size(), 11);
    checkOutput("modelParEven", f[9], 1);
    f = buildFrame(8'h07, 0, 1'b1, 1'b1);
    checkOutput("modelParOdd", f[9], 0);

    // Reset held with a byte waiting and the transmitter enabled
    tick(1);
    fifoQ.push_back(8'hA5);
    enable = 1'b1;
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("firstPop", fifoPop, 1);
    tick(1);
    waitDone(1, 100, "single");
    checkOutput("singleLen", lastDoneCycle - lastPopCycle, 41);
    checkOutput("singlePops", popCount, 1);
    tick(3);

    // Parity, even then odd
    baud = 8'd0; parityEn = 1'b1; parityOdd = 1'b0;
    fifoQ.push_back(8'h07);
    waitDone(2, 50, "parEven");
    checkOutput("parEvenLen", lastDoneCycle - lastPopCycle, 12);
    tick(2);
    parityOdd = 1'b1;
    fifoQ.push_back(8'h07);
    waitDone(3, 50, "parOdd");
    tick(2);

    // Back-to-back
    baud = 8'd1; parityEn = 1'b0;
    busyCount = 0; p0 = popCount; popCycles.delete();
    fifoQ.push_back(8'h01); fifoQ.push_back(8'h80); fifoQ.push_back(8'hFF);
    waitDone(6, 200, "b2b");
    tick(4);
    checkOutput("b2bPops", popCount - p0, 3);
    checkOutput("b2bBusy", busyCount, 60);
    if (popCycles.size() == 3) begin
      checkOutput("b2bGap1", popCycles[1] - popCycles[0], 20);
      checkOutput("b2bGap2", popCycles[2] - popCycles[1], 20);
    end else begin
      checkOutput("b2bPopLog", popCycles.size(), 3);
    end

    // Mid-frame BAUD change and ENABLE drop
    p0 = popCount; d0 = doneCount;
    fifoQ.push_back(8'h3C);
    tick(8);
    fifoQ.push_back(8'h55);
    baud = 8'd7; enable = 1'b0;
    waitDone(d0 + 1, 100, "midFrame");
    checkOutput("midLen", lastDoneCycle - lastPopCycle, 21);
    tick(10);
    checkOutput("midNoPop", popCount - p0, 1);
    enable = 1'b1;
    waitDone(d0 + 2, 200, "reEnable");
    checkOutput("reEnLen", lastDoneCycle - lastPopCycle, 81);
    tick(3);

    // Reset during data bit 4
    baud = 8'd2;
    fifoQ.push_back(8'h0F); fifoQ.push_back(8'h12);
    tick(16);
    p0 = popCount;
    rst = 1'b1; enable = 1'b0;
    #1;
    checkOutput("rstMidTx", tx, 1);
    checkOutput("rstMidBusy", busy, 0);
    tick(3);
    rst = 1'b0;
    tick(3);
    checkOutput("rstMidNoPop", popCount - p0, 0);
    d0 = doneCount;
    enable = 1'b1;
    waitDone(d0 + 1, 100, "afterRst");
    checkOutput("afterRstLen", lastDoneCycle - lastPopCycle, 31);
    tick(3);

    // Largest divisor
    baud = 8'd255; parityEn = 1'b0;
    d0 = doneCount;
    fifoQ.push_back(8'h5A);
    waitDone(d0 + 1, 3000, "baud255");
    checkOutput("baud255Len", lastDoneCycle - lastPopCycle, 2561);
    tick(2);

    applyStimulus(5000);

    rst = 1'b0; enable = 1'b1;
    k = 0;
    while ((fifoQ.size() > 0 || busy) && k < 2000) begin
      tick(1);
      k++;
    end
    checkOutput("drained", fifoQ.size(), 0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

Transmit-side controller for the serial peripheral: sequences bytes out of the transmit FIFO, generates per-bit timing from the baud divisor register, and drives the serial TX line with start, data, optional parity, and stop bits. It sits between the TX FIFO and the TX pin and takes the place of the free-running transmitter. It reports BUSY and a one-cycle DONE pulse that the interrupt logic uses for the "transmit complete" status bit.

## Interface
Parameters:
- DATA_W, 8, character width in bits; data is sent LSB first.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  transmit enable (device enabled AND transmitter enabled status bits).
- BAUD  input  8  baud divisor register value; bit period = BAUD+1 CLK cycles.
- PARITY_EN  input  1  1 = append a parity bit after the data bits.
- PARITY_ODD  input  1  1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- FIFO_EMPTY  input  1  TX FIFO holds no bytes.
- FIFO_DATA  input  DATA_W  FIFO head byte; valid whenever FIFO_EMPTY=0.
- FIFO_POP  output  1  one-cycle pulse; the FIFO removes the head byte on this edge.
- TX  output  1  serial line; idle high.
- BUSY  output  1  a frame is in progress.
- DONE  output  1  one-cycle pulse after the final stop-bit cycle of each frame.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (asynchronous, any state): TX=1, FIFO_POP=0, BUSY=0, DONE=0, state=IDLE. The bit timer, bit index, and shift register clear to 0. A frame in progress is abandoned and no byte is popped.
- IDLE: TX=1. If ENABLE=1 and FIFO_EMPTY=0:
  - assert FIFO_POP combinationally in this cycle;
  - at the edge, capture FIFO_DATA into the shift register and latch BAUD, PARITY_EN, and PARITY_ODD into a frame configuration;
  - go to START with the bit timer set to the latched BAUD.
- START: TX=0 for one bit period, then go to DATA with bit index 0.
- DATA: TX = shift register bit 0, with the shift register moving right once per bit. After bit DATA_W-1, go to PARITY if the latched PARITY_EN=1, otherwise go to STOP.
- PARITY: TX = XOR of the frame's data bits for even parity, or its complement for odd parity. Lasts one bit period, then go to STOP.
- STOP: TX=1 for one bit period. On the last cycle of STOP:
  - if ENABLE=1 and FIFO_EMPTY=0: pop and capture the next byte exactly as in IDLE and go directly to START (back-to-back, no idle gap);
  - otherwise go to IDLE.
- Bit timer: counts down from the latched BAUD to 0, one count per cycle. At 0 the bit ends and the timer reloads. The BAUD=255 maximum gives 256 cycles/bit, and the down-counter must not wrap past 0.
- Configuration is frame-atomic. Changes to BAUD, PARITY_EN, or PARITY_ODD during a frame take effect at the next frame start.
- ENABLE falling mid-frame: the current frame completes normally. No further pop occurs while ENABLE=0.
- FIFO_EMPTY rising mid-frame: no effect on the current frame.
- FIFO_POP is never asserted while FIFO_EMPTY=1, while RESET=1, or outside the IDLE/last-STOP-cycle conditions above.

## Timing
- Pop cycle = cycle n. TX goes low at cycle n+1, and BUSY goes high at n+1.
- A frame occupies (1 + DATA_W + P + 1)·(BAUD+1) cycles starting at n+1, where P = latched PARITY_EN. For DATA_W=8 that is 10·(BAUD+1) or 11·(BAUD+1) cycles.
- DONE is registered: it is high for exactly the one cycle after the final STOP cycle, in parallel with the next frame's first START cycle when running back-to-back.
- BUSY stays high continuously across back-to-back frames. It falls in the cycle after the final STOP cycle when returning to IDLE.
- TX is registered and glitch-free, changing only on CLK edges or on RESET.

## Test plan
- Reset: assert RESET with FIFO non-empty and ENABLE=1 → TX=1, BUSY=0, DONE=0, FIFO_POP=0 throughout reset. First pop occurs on the first cycle after release.
- Single byte: BAUD=3, PARITY_EN=0, FIFO_DATA=0xA5, ENABLE=1 → one FIFO_POP. TX holds each bit for 4 cycles in the sequence 0,1,0,1,0,0,1,0,1,1. The frame lasts 40 cycles, then DONE pulses once and BUSY=0.
- Parity: BAUD=0, FIFO_DATA=0x07, PARITY_EN=1 → with PARITY_ODD=0 the parity bit is 1; with PARITY_ODD=1 it is 0. The frame is 11 cycles.
- Back-to-back: three bytes 0x01, 0x80, 0xFF queued with BAUD=1 → exactly 3 pops spaced 20 cycles apart and no idle cycle between frames. BUSY stays high for 60 cycles, DONE pulses 3 times, and FIFO_POP=0 once the FIFO is empty.
- Mid-frame changes: change BAUD from 1 to 7 and drop ENABLE in the middle of the data bits → the current frame finishes at 2 cycles/bit and no new pop occurs. Re-enabling then produces a frame at 8 cycles/bit.
- Reset mid-frame: assert RESET during DATA bit 4 → TX=1 immediately, the remaining FIFO contents are not popped, and the next frame after release starts cleanly with its start bit.
